// File: rtl/byte_striping_param.sv
// byte_striping_param: serial byte stream to multi-lane word striper.
// Define STRIPE_SKP_EN to insert COM/SKP ordered sets every SKP_INTERVAL words.
module byte_striping_param #(
    parameter int         LANES        = 4,
    parameter logic [7:0] PAD_SYM      = 8'hF7,
    parameter logic [7:0] COM_SYM      = 8'hBC,
    parameter logic [7:0] SKP_SYM      = 8'h1C,
    parameter int         SKP_INTERVAL = 64
) (
    input  logic               CLK,
    input  logic               reset,
    input  logic [7:0]         IN_DATA,
    input  logic               IN_VALID,
    input  logic               IN_LAST,
    output logic               IN_READY,
    input  logic [1:0]         IN_WIDTH,
    output logic [8*LANES-1:0] OUT_LANES,
    output logic [LANES-1:0]   OUT_LANE_ACT,
    output logic               OUT_VALID,
    input  logic               OUT_READY
);

    // Reject configurations the datapath cannot represent
    if (LANES < 1 || LANES > 8 || (LANES & (LANES - 1)) != 0) begin : g_bad_lanes
        $error("LANES must be a power of two in 1..8");
    end
    if (SKP_INTERVAL < 1 || COM_SYM == SKP_SYM) begin : g_bad_skp
        $error("SKP_INTERVAL must be >= 1 and COM/SKP must differ");
    end

    typedef enum logic {FILL, HOLD} state_t;

    state_t     state;
    state_t     state_nxt;
    logic       rdy_q;
    logic [7:0] asm_q [LANES];
    logic [7:0] wnew  [LANES];
    logic [3:0] idx;
    logic [3:0] n_q;
    logic [3:0] req;
    logic [3:0] nsel;
    logic [3:0] n_eff;
    logic [3:0] n_word;
    logic       accept;
    logic       done;
    logic       oreg_free;
    logic       skp_go;
    logic       skp_ld;
    logic       user_ld;
    logic [7:0] skp_byte;

    // Requested width, clamped to the physical lane count
    always_comb begin
        unique case (IN_WIDTH)
            2'd0:    req = 4'd1;
            2'd1:    req = 4'd2;
            2'd2:    req = 4'd4;
            default: req = 4'd8;
        endcase
        nsel = (int'(req) > LANES) ? 4'(LANES) : req;
    end

    // Width is taken from IN_WIDTH only on the first byte of a word
    assign n_eff     = (idx == 4'd0) ? nsel : n_q;
    assign accept    = IN_VALID && rdy_q && (state == FILL);
    assign done      = accept && (IN_LAST || idx == n_eff - 4'd1);
    assign oreg_free = !OUT_VALID || OUT_READY;
    assign n_word    = (state == HOLD) ? n_q : n_eff;
    assign user_ld   = oreg_free && !skp_go
                     && (state == HOLD || done);

    // Word as it would look if the current byte completes it
    always_comb begin
        for (int k = 0; k < LANES; k++) begin
            if (k >= int'(n_eff))
                wnew[k] = 8'h00;
            else if (k < int'(idx))
                wnew[k] = asm_q[k];
            else if (k == int'(idx))
                wnew[k] = IN_DATA;
            else
                wnew[k] = PAD_SYM;
        end
    end

    // State register; IN_READY is registered from the next state
    always_ff @(posedge CLK or posedge reset) begin
        if (reset) begin
            state <= FILL;
            rdy_q <= 1'b0;
        end else begin
            state <= state_nxt;
            rdy_q <= (state_nxt == FILL);
        end
    end

    // Next-state: park in HOLD while a finished word cannot move on
    always_comb begin
        state_nxt = state;
        unique case (state)
            FILL: if (done && !user_ld) state_nxt = HOLD;
            HOLD: if (user_ld)          state_nxt = FILL;
        endcase
    end

    // Output decode
    always_comb begin
        IN_READY = rdy_q;
    end

    // Assembly register: byte index, word width and lane bytes
    always_ff @(posedge CLK or posedge reset) begin
        if (reset) begin
            idx <= 4'd0;
            n_q <= 4'd1;
            for (int k = 0; k < LANES; k++)
                asm_q[k] <= 8'h00;
        end else if (accept) begin
            if (idx == 4'd0)
                n_q <= nsel;
            if (done) begin
                idx <= 4'd0;
                if (!user_ld)
                    for (int k = 0; k < LANES; k++)
                        asm_q[k] <= wnew[k];
            end else begin
                idx <= idx + 4'd1;
                for (int k = 0; k < LANES; k++)
                    if (k == int'(idx))
                        asm_q[k] <= IN_DATA;
            end
        end
    end

    // Output register with valid/ready hold
    always_ff @(posedge CLK or posedge reset) begin
        if (reset) begin
            OUT_LANES    <= '0;
            OUT_LANE_ACT <= '0;
            OUT_VALID    <= 1'b0;
        end else if (user_ld) begin
            OUT_VALID <= 1'b1;
            for (int k = 0; k < LANES; k++) begin
                OUT_LANES[8*k +: 8] <= (state == HOLD) ? asm_q[k] : wnew[k];
                OUT_LANE_ACT[k]     <= (k < int'(n_word));
            end
        end else if (skp_ld) begin
            OUT_VALID <= 1'b1;
            for (int k = 0; k < LANES; k++) begin
                OUT_LANES[8*k +: 8] <= (k < int'(n_q)) ? skp_byte : 8'h00;
                OUT_LANE_ACT[k]     <= (k < int'(n_q));
            end
        end else if (OUT_VALID && OUT_READY) begin
            OUT_VALID <= 1'b0;
        end
    end

`ifdef STRIPE_SKP_EN
    localparam int CW = $clog2(SKP_INTERVAL + 2);

    logic [CW-1:0] wcnt;
    logic [CW-1:0] wcnt_aft;
    logic [1:0]    sidx;
    logic          user_q;

    // Count includes a user word leaving OREG on this edge, so the
    // ordered set follows it with no bubble and no user word slips in
    assign wcnt_aft = wcnt + CW'(OUT_VALID && OUT_READY && user_q);
    assign skp_go   = (wcnt_aft == CW'(SKP_INTERVAL));
    assign skp_ld   = oreg_free && skp_go;
    assign skp_byte = (sidx == 2'd0) ? COM_SYM : SKP_SYM;

    // Word counter and ordered-set sequencer
    always_ff @(posedge CLK or posedge reset) begin
        if (reset) begin
            wcnt   <= '0;
            sidx   <= 2'd0;
            user_q <= 1'b0;
        end else begin
            if (user_ld)
                user_q <= 1'b1;
            else if (skp_ld)
                user_q <= 1'b0;
            if (skp_ld) begin
                if (sidx == 2'd3) begin
                    sidx <= 2'd0;
                    wcnt <= '0;
                end else begin
                    sidx <= sidx + 2'd1;
                    wcnt <= wcnt_aft;
                end
            end else begin
                wcnt <= wcnt_aft;
            end
        end
    end
`else
    assign skp_go   = 1'b0;
    assign skp_ld   = 1'b0;
    assign skp_byte = 8'h00;
`endif

endmodule
